// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 conv path: pixel width, frame size,
// window FSM states and tap ordering seen by the PE.
package conv_pkg;
  localparam int CONV_DW   = 16;
  localparam int IMG_W_DEF = 6;
  localparam int IMG_H_DEF = 6;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } wg_state_e;

  localparam int TAP_N  = 9;
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;
endpackage

// File: rtl/line_buf.sv
// One image row of pixel storage; async read, write on enable,
// so a same-address access returns the old word.
module line_buf import conv_pkg::*; #(
  parameter int DEPTH = IMG_W_DEF,
  parameter int DW    = CONV_DW,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem_q [DEPTH];

  assign o_rdata = mem_q[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_en) mem_q[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator, stride 1, no padding.
// Define WINGEN_FRAME_CNT_EN to add the o_frame_cnt output.
module window_gen_3x3 import conv_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = CONV_DW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic signed [DW-1:0] i_d,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [DW-1:0] o_d0,
  output logic signed [DW-1:0] o_d1,
  output logic signed [DW-1:0] o_d2,
  output logic signed [DW-1:0] o_d3,
  output logic signed [DW-1:0] o_d4,
  output logic signed [DW-1:0] o_d5,
  output logic signed [DW-1:0] o_d6,
  output logic signed [DW-1:0] o_d7,
  output logic signed [DW-1:0] o_d8,
  output logic                 o_last
`ifdef WINGEN_FRAME_CNT_EN
  ,
  output logic [15:0]          o_frame_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);

  wg_state_e     state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] win_q [TAP_N];
  logic [DW-1:0] win_d [TAP_N];
  logic [DW-1:0] tap_q [TAP_N];
  logic [DW-1:0] tap_d [TAP_N];
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [DW-1:0] lb0_rd, lb1_rd;
  logic          accept, xfer, produce;
  logic          col_end, frame_end;

  assign o_ready   = !valid_q | i_ready;
  assign accept    = i_valid & o_ready;
  assign xfer      = valid_q & i_ready;
  assign col_end   = (col_q == COL_END);
  assign frame_end = col_end && (row_q == ROW_END);
  assign produce   = accept && (state_q == S_RUN)
                     && (col_q >= CW'(2));

  line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .i_clk   (i_clk),
    .i_en    (accept),
    .i_addr  (col_q),
    .i_wdata (i_d),
    .o_rdata (lb0_rd)
  );

  line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .i_clk   (i_clk),
    .i_en    (accept),
    .i_addr  (col_q),
    .i_wdata (lb0_rd),
    .o_rdata (lb1_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    tap_d   = tap_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]   = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[TAP_TR] = lb1_rd;
      win_d[TAP_MR] = lb0_rd;
      win_d[TAP_BR] = i_d;
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end)
        row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
      unique case (state_q)
        S_FILL:
          if (col_end && row_q == RW'(1)) state_d = S_RUN;
        S_RUN:
          if (frame_end) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
    // a window loaded here overrides any clear from a same-cycle transfer
    if (produce) begin
      tap_d   = win_d;
      valid_d = 1'b1;
      last_d  = frame_end;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < TAP_N; i++) begin
        win_q[i] <= '0;
        tap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      win_q   <= win_d;
      tap_q   <= tap_d;
    end
  end

  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_d0    = tap_q[TAP_TL];
  assign o_d1    = tap_q[TAP_TC];
  assign o_d2    = tap_q[TAP_TR];
  assign o_d3    = tap_q[TAP_ML];
  assign o_d4    = tap_q[TAP_MC];
  assign o_d5    = tap_q[TAP_MR];
  assign o_d6    = tap_q[TAP_BL];
  assign o_d7    = tap_q[TAP_BC];
  assign o_d8    = tap_q[TAP_BR];

`ifdef WINGEN_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (xfer && last_q) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

  assign o_frame_cnt = fcnt_q;
`endif
endmodule
